// File: rtl/bnn_argmax_out.sv
// bnn_argmax_out: latches the final layer's class scores and scans them
// for the argmax. ARGMAX_MARGIN_EN adds margin_out (best - second best).
module bnn_argmax_out #(
  parameter int N_CLASS = 10,
  parameter int SCORE_W = 6,
  parameter int IDX_W   = $clog2(N_CLASS)
) (
  input  logic                       clk,
  input  logic                       xrst,
  output logic                       in_req,
  input  logic                       in_ack,
  input  logic [N_CLASS*SCORE_W-1:0] scores,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           class_out,
  output logic [SCORE_W-1:0]         max_out,
`ifdef ARGMAX_MARGIN_EN
  output logic [SCORE_W-1:0]         margin_out,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {
    ST_REQ, ST_DROP, ST_SCAN, ST_OUT
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASS - 1);

  state_t                     state_q, state_d;
  logic [N_CLASS*SCORE_W-1:0] scores_q, scores_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [SCORE_W-1:0]         best_q, best_d;
  logic [IDX_W-1:0]           class_q, class_d;
  logic [SCORE_W-1:0]         s_cur;
  logic                       scan, first, new_best;

  always_comb begin
    s_cur = '0;
    for (int k = 0; k < N_CLASS; k++) begin
      if (idx_q == IDX_W'(k)) s_cur = scores_q[k*SCORE_W +: SCORE_W];
    end
  end

  assign scan     = (state_q == ST_SCAN);
  assign first    = scan && (idx_q == '0);
  assign new_best = scan && (idx_q != '0) && (s_cur > best_q);

  always_comb begin
    state_d  = state_q;
    scores_d = scores_q;
    idx_d    = idx_q;
    best_d   = best_q;
    class_d  = class_q;
    unique case (state_q)
      ST_REQ: begin
        if (in_ack) begin
          scores_d = scores;
          state_d  = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!in_ack) begin
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (first || new_best) begin
          best_d  = s_cur;
          class_d = idx_q;
        end
        if (idx_q == LAST) state_d = ST_OUT;
        else idx_d = idx_q + IDX_W'(1);
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q  <= ST_REQ;
      scores_q <= '0;
      idx_q    <= '0;
      best_q   <= '0;
      class_q  <= '0;
    end else begin
      state_q  <= state_d;
      scores_q <= scores_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      class_q  <= class_d;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0] second_q, second_d;
  logic [SCORE_W-1:0] margin_q, margin_d;

  // Ties for best fall into the second branch, giving a zero margin.
  always_comb begin
    second_d = second_q;
    margin_d = margin_q;
    if (first) second_d = '0;
    else if (new_best) second_d = best_q;
    else if (scan && (s_cur > second_q)) second_d = s_cur;
    if (scan) margin_d = best_d - second_d;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      second_q <= '0;
      margin_q <= '0;
    end else begin
      second_q <= second_d;
      margin_q <= margin_d;
    end
  end

  assign margin_out = margin_q;
`endif

  assign in_req    = (state_q == ST_REQ);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_REQ);
  assign class_out = class_q;
  assign max_out   = best_q;

endmodule

// File: tb/tb_bnn_argmax_out.sv
// Directed and random-frame bench for bnn_argmax_out with an
// expected-result scoreboard; margin checks when ARGMAX_MARGIN_EN is set.
module tb_bnn_argmax_out;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        in_req, in_ack, out_valid, out_ready, busy;
  logic [59:0] scores;
  logic [3:0]  class_out;
  logic [5:0]  max_out;
`ifdef ARGMAX_MARGIN_EN
  logic [5:0]  margin_out;
`endif

  typedef struct packed {
    logic [3:0] cls;
    logic [5:0] mx;
    logic [5:0] mg;
  } res_t;

  res_t sb[$];
  int   passed = 0;
  int   total  = 0;

  bnn_argmax_out dut (
    .clk       (clk),
    .xrst      (xrst),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .scores    (scores),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_out (class_out),
    .max_out   (max_out),
`ifdef ARGMAX_MARGIN_EN
    .margin_out(margin_out),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [59:0] pk(input int a[10]);
    logic [59:0] v = '0;
    for (int k = 0; k < 10; k++) v[k*6 +: 6] = 6'(a[k]);
    return v;
  endfunction

  function automatic logic [59:0] rnd(input int lim);
    logic [59:0] v = '0;
    for (int k = 0; k < 10; k++) v[k*6 +: 6] = 6'($urandom_range(0, lim));
    return v;
  endfunction

  function automatic res_t model(input logic [59:0] v);
    res_t r;
    logic [5:0] b, s, sec;
    int c;
    b = v[5:0];
    c = 0;
    for (int k = 1; k < 10; k++) begin
      s = v[k*6 +: 6];
      if (s > b) begin b = s; c = k; end
    end
    sec = '0;
    for (int k = 0; k < 10; k++) begin
      s = v[k*6 +: 6];
      if (k != c && s > sec) sec = s;
    end
    r.cls = 4'(c);
    r.mx  = b;
    r.mg  = b - sec;
    return r;
  endfunction

  task automatic frame(input logic [59:0] sv, input int ack_len,
                       input int hold);
    res_t e;
    int   cyc;
    logic [3:0] c0;
    logic [5:0] m0;
    cyc = 0;
    while (!in_req && cyc < 50) begin tick; cyc++; end
    chk("req_ready", 32'(in_req), 1);
    scores = sv;
    in_ack = 1'b1;
    out_ready = (hold == 0);
    sb.push_back(model(sv));
    tick;
    chk("req_drop", 32'(in_req), 0);
    chk("busy_drop", 32'(busy), 1);
    scores = rnd(63);
    repeat (ack_len - 1) begin
      tick;
      chk("no_scan_ack", 32'(out_valid), 0);
      chk("req_low_ack", 32'(in_req), 0);
    end
    in_ack = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin tick; cyc++; end
    chk("ack_low_latency", cyc, 11);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("class_out", 32'(class_out), 32'(e.cls));
      chk("max_out", 32'(max_out), 32'(e.mx));
`ifdef ARGMAX_MARGIN_EN
      chk("margin_out", 32'(margin_out), 32'(e.mg));
`endif
    end
    if (hold > 0) begin
      c0 = class_out;
      m0 = max_out;
      scores = rnd(63);
      repeat (hold) begin
        tick;
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_class", 32'(class_out), 32'(c0));
        chk("hold_max", 32'(max_out), 32'(m0));
        chk("hold_req", 32'(in_req), 0);
      end
      out_ready = 1'b1;
    end
    tick;
    chk("req_back", 32'(in_req), 1);
    chk("valid_drop", 32'(out_valid), 0);
  endtask

  initial begin
    int a[10];
    in_ack = 1'b0;
    out_ready = 1'b1;
    scores = '0;
    tick;
    tick;
    chk("rst_req", 32'(in_req), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_class", 32'(class_out), 0);
    chk("rst_max", 32'(max_out), 0);
    xrst = 1'b1;
    tick;
    chk("req_after_rst", 32'(in_req), 1);

    // reset in the middle of a scan
    a = '{3, 50, 1, 1, 1, 1, 1, 1, 1, 1};
    scores = pk(a);
    in_ack = 1'b1;
    tick;
    in_ack = 1'b0;
    repeat (4) tick;
    chk("midscan_busy", 32'(busy), 1);
    xrst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(in_req), 1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_class", 32'(class_out), 0);
    chk("mid_rst_max", 32'(max_out), 0);
    tick;
    xrst = 1'b1;
    tick;

    a = '{5, 9, 3, 40, 12, 0, 7, 40, 1, 2};
    frame(pk(a), 1, 0);
    a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 33};
    frame(pk(a), 1, 0);
    a = '{10, 20, 30, 62, 1, 2, 3, 4, 61, 5};
    frame(pk(a), 5, 0);
    a = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 8};
    frame(pk(a), 2, 20);
    frame('0, 1, 0);
    frame({60{1'b1}}, 1, 0);
    a = '{63, 0, 0, 0, 0, 0, 0, 0, 0, 62};
    frame(pk(a), 1, 3);

    for (int f = 0; f < 100; f++) begin
      frame(rnd((f % 3 == 0) ? 7 : 63), 1, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
